mem_port_arbiter: RTL

- Shares the single unified memory port of the multicycle core between the instruction-fetch requester (port 0) and the load/store requester (port 1).
- Sequences each access through a fixed-latency memory.
- Owns the select of the address/write-data mux2x1 instances in front of the memory: sel=0 selects port 0, sel=1 selects port 1.
- Returns read data with a one-cycle acknowledge pulse to the granted requester.

---
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// mem_port_arbiter: round-robin sharing of one fixed-latency memory port
// between instruction fetch (port 0) and load/store (port 1). Rev 1.0
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mux_sel,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic              mux_sel_q, mux_sel_d;
    logic              last_q, last_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              grant;
    logic              first_cycle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mux_sel_q <= 1'b0;
            last_q    <= 1'b1;
            cnt_q     <= 4'd0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            mux_sel_q <= mux_sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    // The counter starts at MEM_LAT-1 and only counts down, so the load value
    // uniquely marks the first ACCESS cycle (also when MEM_LAT=1).
    assign first_cycle = (cnt_q == CNT_LOAD);

    always_comb begin
        state_d   = state_q;
        mux_sel_d = mux_sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        grant     = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    grant     = (req0 && req1) ? ~last_q : req1;
                    mux_sel_d = grant;
                    last_d    = grant;
                    cnt_d     = CNT_LOAD;
                    state_d   = S_ACCESS;
                end
            end
            S_ACCESS: begin
                mem_en = first_cycle;
                mem_we = first_cycle & we1 & mux_sel_q;
                if (cnt_q == 4'd0) begin
                    if (!(mux_sel_q && we1)) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                ack0    = ~mux_sel_q;
                ack1    = mux_sel_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem_addr  = mux_sel_q ? addr1 : addr0;
    assign mem_wdata = wdata1;
    assign mux_sel   = mux_sel_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire
